// File: rtl/mii_reg_mirror.sv
// Shadow of the 32x16 PHY register space fed by the MDIO sweep engine.
// Tracks change flags, sweep count, link status and link drops, and serves a host read port.
module mii_reg_mirror #(
  parameter logic [4:0] LINK_REG = 5'd1,
  parameter int         LINK_BIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic [4:0]  addr,
  input  logic [15:0] data,
  input  logic        host_rd,
  input  logic [4:0]  host_addr,
  input  logic        host_clr,
  output logic [15:0] host_data,
  output logic        host_valid,
  output logic [31:0] changed,
  output logic        all_valid,
  output logic [15:0] sweep_count,
  output logic        link_up,
  output logic [7:0]  link_drop_cnt
);

  logic [15:0] mem [32];
  logic [31:0] valid;
  logic [31:0] addr_dec;
  logic [15:0] old_word;
  logic        hit_change;
  logic        link_bit;
  logic        is_link_strobe;
  logic        is_sweep_end;

  assign addr_dec       = 32'd1 << addr;
  assign old_word       = mem[addr];
  assign hit_change     = strobe && valid[addr] && (data != old_word);
  assign link_bit       = data[LINK_BIT];
  assign is_link_strobe = strobe && (addr == LINK_REG);
  assign is_sweep_end   = strobe && (addr == 5'd31);

  // Storage itself is not reset; valid bits gate every observable use of it.
  always_ff @(posedge clk) begin
    if (strobe) mem[addr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid         <= '0;
      changed       <= '0;
      all_valid     <= 1'b0;
      sweep_count   <= '0;
      link_up       <= 1'b0;
      link_drop_cnt <= '0;
      host_data     <= '0;
      host_valid    <= 1'b0;
    end else begin
      if (strobe) valid <= valid | addr_dec;

      // A change detected in the same cycle as host_clr survives the clear.
      changed <= (host_clr ? 32'd0 : changed) | (hit_change ? addr_dec : 32'd0);

      all_valid <= &valid;

      if (is_sweep_end) sweep_count <= sweep_count + 16'd1;

      if (is_link_strobe) begin
        link_up <= link_bit;
        if (link_up && !link_bit && (link_drop_cnt != 8'hFF))
          link_drop_cnt <= link_drop_cnt + 8'd1;
      end

      // Reads use pre-write state, so a same-cycle strobe is not visible yet.
      host_valid <= host_rd;
      if (host_rd) host_data <= valid[host_addr] ? mem[host_addr] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_mii_reg_mirror.sv
// Randomized and directed bench for mii_reg_mirror; host reads are checked
// through a scoreboard queue against an array-based reference model.
module tb_mii_reg_mirror;

  localparam logic [4:0] LREG = 5'd1;
  localparam int         LBIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [4:0]  addr;
  logic [15:0] data;
  logic        host_rd;
  logic [4:0]  host_addr;
  logic        host_clr;
  logic [15:0] host_data;
  logic        host_valid;
  logic [31:0] changed;
  logic        all_valid;
  logic [15:0] sweep_count;
  logic        link_up;
  logic [7:0]  link_drop_cnt;

  mii_reg_mirror #(.LINK_REG(LREG), .LINK_BIT(LBIT)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .data(data),
    .host_rd(host_rd), .host_addr(host_addr), .host_clr(host_clr),
    .host_data(host_data), .host_valid(host_valid), .changed(changed),
    .all_valid(all_valid), .sweep_count(sweep_count), .link_up(link_up),
    .link_drop_cnt(link_drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [15:0] m_mem [32];
  logic        m_valid [32];
  logic [31:0] m_changed;
  logic        m_all_valid;
  int          m_sweep;
  logic        m_link;
  int          m_drop;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_changed   = '0;
    m_all_valid = 1'b0;
    m_sweep     = 0;
    m_link      = 1'b0;
    m_drop      = 0;
    exp_q.delete();
  endtask

  function automatic logic all_captured();
    for (int i = 0; i < 32; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outputs();
    chk("changed", changed, m_changed);
    chk("all_valid", {31'd0, all_valid}, {31'd0, m_all_valid});
    chk("sweep_count", {16'd0, sweep_count}, 32'(m_sweep));
    chk("link_up", {31'd0, link_up}, {31'd0, m_link});
    chk("link_drop_cnt", {24'd0, link_drop_cnt}, 32'(m_drop));
  endtask

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic step(input logic s, input logic [4:0] a, input logic [15:0] d,
                      input logic rd, input logic [4:0] ra, input logic clr,
                      input logic do_chk = 1'b1);
    logic [31:0] nchg;
    logic        nav;
    strobe = s; addr = a; data = d; host_rd = rd; host_addr = ra; host_clr = clr;
    if (rd) exp_q.push_back(m_valid[ra] ? m_mem[ra] : 16'h0000);
    nav  = all_captured();
    nchg = clr ? 32'd0 : m_changed;
    if (s) begin
      if (m_valid[a] && m_mem[a] != d) nchg[a] = 1'b1;
      m_mem[a]   = d;
      m_valid[a] = 1'b1;
      if (a == 5'd31) m_sweep = (m_sweep + 1) % 65536;
      if (a == LREG) begin
        if (m_link && !d[LBIT] && m_drop < 255) m_drop++;
        m_link = d[LBIT];
      end
    end
    m_changed   = nchg;
    m_all_valid = nav;
    @(posedge clk);
    #1;
    strobe = 1'b0; host_rd = 1'b0; host_clr = 1'b0;
    if (do_chk) check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_changed"}, changed, 32'd0);
    chk({tag, "_all_valid"}, {31'd0, all_valid}, 32'd0);
    chk({tag, "_sweep"}, {16'd0, sweep_count}, 32'd0);
    chk({tag, "_link"}, {31'd0, link_up}, 32'd0);
    chk({tag, "_drop"}, {24'd0, link_drop_cnt}, 32'd0);
    chk({tag, "_hdata"}, {16'd0, host_data}, 32'd0);
    chk({tag, "_hvalid"}, {31'd0, host_valid}, 32'd0);
  endtask

  // Asynchronous reset pulse, issued between edges.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && host_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL host_valid_extra: got host_valid=1 data=%0h required no pending read", host_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (host_data !== e) begin
          bad++;
          $display("FAIL host_data: got %0h required %0h", host_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; strobe = 1'b0; addr = '0; data = '0;
    host_rd = 1'b0; host_addr = '0; host_clr = 1'b0;
    model_reset();
    #3;
    check_all_zero("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First sweep
    for (int k = 0; k < 32; k++) step(1'b1, 5'(k), 16'(k) * 16'h0101, 1'b0, 5'd0, 1'b0);
    chk("sweep1_count", {16'd0, sweep_count}, 32'd1);
    idle(1);
    chk("sweep1_all_valid", {31'd0, all_valid}, 32'd1);
    chk("sweep1_changed", changed, 32'd0);
    step(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 1'b0);
    idle(2);

    // Second sweep, reg 3 differs
    for (int k = 0; k < 32; k++)
      step(1'b1, 5'(k), (k == 3) ? 16'hBEEF : 16'(k) * 16'h0101, 1'b0, 5'd0, 1'b0);
    chk("sweep2_changed", changed, 32'h8);
    chk("sweep2_count", {16'd0, sweep_count}, 32'd2);
    step(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 1'b1);
    chk("clr_changed", changed, 32'd0);
    step(1'b1, 5'd7, 16'hAAAA, 1'b0, 5'd0, 1'b1);
    chk("clr_coincide", changed, 32'h80);

    // Link tracking
    step(1'b1, LREG, 16'h0004, 1'b0, 5'd0, 1'b0);
    step(1'b1, LREG, 16'h0000, 1'b0, 5'd0, 1'b0);
    step(1'b1, LREG, 16'h0000, 1'b0, 5'd0, 1'b0);
    step(1'b1, LREG, 16'h0004, 1'b0, 5'd0, 1'b0);
    step(1'b1, LREG, 16'h0000, 1'b0, 5'd0, 1'b0);
    chk("link_drops2", {24'd0, link_drop_cnt}, 32'd2);
    chk("link_final", {31'd0, link_up}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, LREG, 16'h0004, 1'b0, 5'd0, 1'b0);
      step(1'b1, LREG, 16'h0000, 1'b0, 5'd0, 1'b0);
    end
    chk("link_sat", {24'd0, link_drop_cnt}, 32'd255);

    // Fresh reset, read before capture and collision
    do_reset("rst2");
    step(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 1'b0);
    step(1'b1, 5'd9, 16'h1234, 1'b1, 5'd9, 1'b0);
    step(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 1'b0);
    step(1'b1, 5'd9, 16'h4321, 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 1'b0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic s, rd, clr;
      s   = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 1) != 0);
      clr = ($urandom_range(0, 15) == 0);
      step(s, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 7)),
           rd, 5'($urandom_range(0, 31)), clr);
    end
    idle(2);

    // Reset mid-sweep with a read in flight
    for (int k = 0; k < 10; k++) step(1'b1, 5'(k), 16'hA000 + 16'(k), 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 16'h0, 1'b1, 5'd2, 1'b0);
    do_reset("rst_mid");
    step(1'b1, 5'd2, 16'h5555, 1'b0, 5'd0, 1'b0);
    chk("rst_first_capture", {31'd0, changed[2]}, 32'd0);
    step(1'b0, 5'd0, 16'h0, 1'b1, 5'd2, 1'b0);
    idle(2);

    // Sweep counter wrap
    do_reset("rst_wrap");
    for (int i = 0; i < 65536; i++) step(1'b1, 5'd31, 16'(i), 1'b0, 5'd0, 1'b0, 1'b0);
    chk("sweep_wrap", {16'd0, sweep_count}, 32'd0);
    chk("wrap_changed31", changed, 32'h8000_0000);
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
